sparc_exu_div_ovfl_seq: RTL and testbench
=========================================

Name: sparc_exu_div_ovfl_seq

Overview:
- Sequencer for one shared 32-bit "all bits equal" checker (eql_in -> eql_out) in the EXU divide path.
- Two requesters share it:
  - req 0: divide-result overflow check.
  - req 1: integer-multiply 64->32 narrowing check.
- Arbitrates round-robin and runs one or two checker passes per request.
- Returns an overflow flag plus the 32-bit saturation value.

Parameters:
- EQL_LAT, 0, checker latency in cycles. 0 = eql_out valid in the same cycle as eql_in. 1 = eql_out registered, valid one cycle later.

Ports:
- rclk  in  1  clock
- arst_l  in  1  asynchronous active-low reset
- req_vld  in  2  per-requester request valid; level, held until ack
- req0_data  in  64  requester 0 value to narrow
- req1_data  in  64  requester 1 value to narrow
- req_signed  in  2  per-requester signed(1)/unsigned(0) check
- req_kill  in  2  per-requester abort of in-flight or pending request
- req_ack  out  2  one-hot pulse: request accepted and data latched
- eql_in  out  32  operand to shared equality checker
- eql_out  in  1  checker result, 1 = all 32 bits equal
- rsp_vld  out  1  one-cycle response pulse
- rsp_id  out  1  requester owning the response
- rsp_ovfl  out  1  value does not fit in 32 bits
- rsp_sat  out  32  saturated result, valid when rsp_ovfl=1

Behaviour:
- Clock/reset: one clock (rclk); arst_l asynchronous, active low. Reset (async assert, sync deassert handled upstream) values:
  - FSM = IDLE; rr pointer = 0 (requester 0 has priority first).
  - req_ack = 0, rsp_vld = 0, rsp_id = 0, rsp_ovfl = 0, rsp_sat = 0, eql_in = 0.
- FSM states: IDLE, P1, P1W, P2, P2W, DONE. P1W and P2W are used only when EQL_LAT=1.
- IDLE:
  - Eligible requests are req_vld & ~req_kill.
  - If any request is eligible: grant per rr pointer (pointer requester wins when both valid). Pulse req_ack for the winner in this cycle, latch data/signed/id, advance the pointer to the other requester, go to P1.
  - eql_in = 0 in IDLE.
- P1:
  - eql_in = latched[63:32].
  - EQL_LAT=1: go to P1W and sample there, with eql_in held.
  - Sample decisions:
    - Unsigned: ovfl = ~(eql_out & ~latched[63]), i.e. the upper half is nonzero. Go to DONE.
    - Signed, eql_out=0: ovfl = 1, go to DONE.
    - Signed, eql_out=1: go to P2.
- P2:
  - eql_in = {latched[32], latched[31], {30{latched[31]}}}.
  - EQL_LAT=1: go to P2W and sample there.
  - ovfl = ~eql_out. Go to DONE.
- DONE:
  - rsp_vld = 1 for exactly one cycle, with rsp_id/rsp_ovfl/rsp_sat registered. Return to IDLE.
  - No grant in DONE; the next grant happens at the earliest in the following IDLE cycle.
- rsp_sat:
  - Unsigned: 0xFFFFFFFF.
  - Signed: latched[63] ? 0x80000000 : 0x7FFFFFFF.
  - 0 when rsp_ovfl=0.
- Latency from the ack cycle to rsp_vld, EQL_LAT=0:
  - Unsigned: 2 cycles.
  - Signed early-overflow: 2 cycles.
  - Signed full check: 3 cycles.
  - EQL_LAT=1 adds 1 cycle per pass executed.
- Kill:
  - req_kill of the owner in any state other than IDLE returns the FSM to IDLE next cycle with no rsp_vld.
  - The rr pointer is not reverted.
  - Kill asserted in the DONE cycle suppresses rsp_vld.
  - Kill of the non-owner has no effect on the current operation.
- Simultaneous requests: both requesters valid in IDLE -> pointer requester granted; the other is granted in the next IDLE.
- req_vld dropped without ack is legal; no state change.
- Reset mid-operation: immediate return to reset values. The in-flight request is lost and no response is issued.
- Back-to-back: a requester may reassert in the cycle after its ack.

Test Plan:
- Reset, then unsigned req 0, data 0x0000_0000_1234_5678 -> ack in cycle 0, eql_in = 0 in P1, rsp_vld in cycle 2 with id 0, ovfl 0, sat 0.
- Signed req 1, data 0xFFFF_FFFF_8000_0000 -> P1 and P2 both see eql_out=1, rsp in cycle 3, ovfl 0. Then data 0xFFFF_FFFF_7FFF_FFFF -> P2 eql_in = 0x8000_0000 pattern gives eql_out=0, ovfl 1, sat 0x8000_0000.
- Signed req 0, data 0x0000_0001_0000_0000 -> P1 eql_out=0, rsp in cycle 2, ovfl 1, sat 0x7FFF_FFFF. Unsigned variant -> sat 0xFFFF_FFFF.
- Both req_vld held high for 6 requests -> grants alternate 0,1,0,1,0,1, with no IDLE gap other than the mandatory DONE->IDLE cycle.
- Signed req 0 killed in P2 -> no rsp_vld, FSM back in IDLE next cycle. Pending req 1 is acked the following cycle.
- EQL_LAT=1 with the scenario 2 data -> rsp in cycle 5; eql_in held for 2 cycles in each pass. arst_l pulsed in P1W -> all outputs 0 immediately, no response.

Source files
------------

// File: rtl/sparc_exu_div_ovfl_seq.sv
// rtl/sparc_exu_div_ovfl_seq.sv - round-robin sequencer sharing one 32-bit all-bits-equal checker
module sparc_exu_div_ovfl_seq #(
  parameter int EQL_LAT = 0
) (
  input  logic        rclk,
  input  logic        arst_l,
  input  logic [1:0]  req_vld,
  input  logic [63:0] req0_data,
  input  logic [63:0] req1_data,
  input  logic [1:0]  req_signed,
  input  logic [1:0]  req_kill,
  output logic [1:0]  req_ack,
  output logic [31:0] eql_in,
  input  logic        eql_out,
  output logic        rsp_vld,
  output logic        rsp_id,
  output logic        rsp_ovfl,
  output logic [31:0] rsp_sat
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P1W  = 3'd2,
    S_P2   = 3'd3,
    S_P2W  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  // Only bits [63:31] of the request ever reach the checker or the saturation choice.
  logic [32:0] data_q, data_d;
  logic        sgn_q, sgn_d;
  logic        id_q, id_d;
  logic        ovfl_q, ovfl_d;
  logic [31:0] sat_q, sat_d;

  logic [1:0]  elig;
  logic        grant_vld;
  logic        grant_id;
  logic        owner_kill;
  logic        sample_p1;
  logic        sample_p2;
  logic [31:0] sat_val;
  logic        unused_low;

  assign unused_low = ^{req0_data[30:0], req1_data[30:0]};

  // Arbitration, kill detection and the cycle in which each pass reads the checker.
  always_comb begin
    elig      = req_vld & ~req_kill;
    grant_vld = |elig;
    grant_id  = (&elig) ? rr_q : elig[1];
    owner_kill = req_kill[id_q];
    sample_p1 = (EQL_LAT == 0) ? (state_q == S_P1) : (state_q == S_P1W);
    sample_p2 = (EQL_LAT == 0) ? (state_q == S_P2) : (state_q == S_P2W);
    sat_val   = !sgn_q ? 32'hFFFF_FFFF : (data_q[32] ? 32'h8000_0000 : 32'h7FFF_FFFF);
  end

  // State register and latched request context.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      data_q  <= '0;
      sgn_q   <= 1'b0;
      id_q    <= 1'b0;
      ovfl_q  <= 1'b0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      sgn_q   <= sgn_d;
      id_q    <= id_d;
      ovfl_q  <= ovfl_d;
      sat_q   <= sat_d;
    end
  end

  // Next state: grant in IDLE, owner kill aborts, otherwise walk the passes.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    data_d  = data_q;
    sgn_d   = sgn_q;
    id_d    = id_q;
    ovfl_d  = ovfl_q;
    sat_d   = sat_q;
    if (state_q == S_IDLE) begin
      if (grant_vld) begin
        state_d = S_P1;
        rr_d    = ~grant_id;
        id_d    = grant_id;
        data_d  = grant_id ? req1_data[63:31] : req0_data[63:31];
        sgn_d   = req_signed[grant_id];
        ovfl_d  = 1'b0;
        sat_d   = '0;
      end
    end else if (owner_kill) begin
      state_d = S_IDLE;
    end else if (sample_p1) begin
      if (!sgn_q) begin
        ovfl_d  = ~(eql_out & ~data_q[32]);
        sat_d   = ~(eql_out & ~data_q[32]) ? sat_val : 32'h0;
        state_d = S_DONE;
      end else if (!eql_out) begin
        ovfl_d  = 1'b1;
        sat_d   = sat_val;
        state_d = S_DONE;
      end else begin
        state_d = S_P2;
      end
    end else if (sample_p2) begin
      ovfl_d  = ~eql_out;
      sat_d   = eql_out ? 32'h0 : sat_val;
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_P1:    state_d = S_P1W;
        S_P2:    state_d = S_P2W;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: ack pulse on grant, checker operand per pass, response in DONE unless killed.
  always_comb begin
    req_ack  = 2'b00;
    eql_in   = '0;
    rsp_vld  = 1'b0;
    rsp_id   = 1'b0;
    rsp_ovfl = 1'b0;
    rsp_sat  = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) req_ack = grant_id ? 2'b10 : 2'b01;
      end
      S_P1, S_P1W: eql_in = data_q[32:1];
      S_P2, S_P2W: eql_in = {data_q[1], data_q[0], {30{data_q[0]}}};
      S_DONE: begin
        if (!owner_kill) begin
          rsp_vld  = 1'b1;
          rsp_id   = id_q;
          rsp_ovfl = ovfl_q;
          rsp_sat  = sat_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sparc_exu_div_ovfl_seq.sv
// tb/tb_sparc_exu_div_ovfl_seq.sv - bench for sparc_exu_div_ovfl_seq at EQL_LAT 0 and 1
module tb_sparc_exu_div_ovfl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_l;
  logic [1:0]  vld [2];
  logic [63:0] d0 [2];
  logic [63:0] d1 [2];
  logic [1:0]  sg [2];
  logic [1:0]  kl [2];
  logic [1:0]  ack [2];
  logic [31:0] ein [2];
  logic        rv [2];
  logic        rid [2];
  logic        rov [2];
  logic [31:0] rsat [2];
  logic        eout0;
  logic        eout1;

  int n_chk = 0;
  int n_fail = 0;

  sparc_exu_div_ovfl_seq #(.EQL_LAT(0)) dut0 (
    .rclk(clk), .arst_l(arst_l), .req_vld(vld[0]), .req0_data(d0[0]), .req1_data(d1[0]),
    .req_signed(sg[0]), .req_kill(kl[0]), .req_ack(ack[0]), .eql_in(ein[0]), .eql_out(eout0),
    .rsp_vld(rv[0]), .rsp_id(rid[0]), .rsp_ovfl(rov[0]), .rsp_sat(rsat[0]));

  sparc_exu_div_ovfl_seq #(.EQL_LAT(1)) dut1 (
    .rclk(clk), .arst_l(arst_l), .req_vld(vld[1]), .req0_data(d0[1]), .req1_data(d1[1]),
    .req_signed(sg[1]), .req_kill(kl[1]), .req_ack(ack[1]), .eql_in(ein[1]), .eql_out(eout1),
    .rsp_vld(rv[1]), .rsp_id(rid[1]), .rsp_ovfl(rov[1]), .rsp_sat(rsat[1]));

  // Checker environment: combinational for instance 0, one-cycle registered for instance 1.
  assign eout0 = (ein[0] == 32'h0) || (ein[0] == 32'hFFFF_FFFF);
  always @(posedge clk) eout1 <= (ein[1] == 32'h0) || (ein[1] == 32'hFFFF_FFFF);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: value-level rules for overflow, saturation and pass count.
  function automatic bit fits(input logic [63:0] d, input bit s);
    if (!s) return d <= 64'h0000_0000_FFFF_FFFF;
    return ($signed(d) >= -64'sd2147483648) && ($signed(d) <= 64'sd2147483647);
  endfunction

  function automatic logic [31:0] exp_sat(input logic [63:0] d, input bit s);
    if (fits(d, s)) return 32'h0;
    if (!s) return 32'hFFFF_FFFF;
    return ($signed(d) < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  function automatic int exp_lat(input logic [63:0] d, input bit s, input int l);
    int passes;
    passes = 1;
    if (s && ($signed(d) >= -64'sd4294967296) && ($signed(d) <= 64'sd4294967295)) passes = 2;
    return passes * (1 + l) + 1;
  endfunction

  bit          m_busy [2];
  bit          m_ptr [2];
  bit          m_own [2];
  logic [63:0] m_data [2];
  bit          m_sgn [2];
  int          m_el [2];
  int          m_lat [2];
  logic [1:0]  last_ack [2];

  task automatic model_cycle(input int k);
    logic [1:0]  e;
    logic [1:0]  xack;
    logic [31:0] xein;
    bit          w;
    bit          xrv;
    int          pass;
    xack = 2'b00;
    xrv  = 1'b0;
    if (!m_busy[k]) begin
      e = vld[k] & ~kl[k];
      chk($sformatf("i%0d idle eql_in", k), ein[k], 64'h0);
      if (e != 2'b00) begin
        w         = (e == 2'b11) ? m_ptr[k] : e[1];
        xack      = w ? 2'b10 : 2'b01;
        m_busy[k] = 1'b1;
        m_own[k]  = w;
        m_data[k] = w ? d1[k] : d0[k];
        m_sgn[k]  = sg[k][w];
        m_el[k]   = 0;
        m_lat[k]  = exp_lat(m_data[k], m_sgn[k], k);
        m_ptr[k]  = ~w;
      end
    end else begin
      m_el[k]++;
      if (kl[k][m_own[k]]) begin
        m_busy[k] = 1'b0;
      end else if (m_el[k] == m_lat[k]) begin
        xrv = 1'b1;
        m_busy[k] = 1'b0;
        chk($sformatf("i%0d rsp_id", k), rid[k], m_own[k]);
        chk($sformatf("i%0d rsp_ovfl", k), rov[k], !fits(m_data[k], m_sgn[k]));
        chk($sformatf("i%0d rsp_sat", k), rsat[k], exp_sat(m_data[k], m_sgn[k]));
      end else begin
        pass = (m_el[k] - 1) / (1 + k);
        xein = (pass == 0) ? m_data[k][63:32]
                           : {m_data[k][32], m_data[k][31], {30{m_data[k][31]}}};
        chk($sformatf("i%0d pass%0d eql_in", k, pass), ein[k], xein);
      end
    end
    chk($sformatf("i%0d req_ack", k), ack[k], xack);
    chk($sformatf("i%0d rsp_vld", k), rv[k], xrv);
  endtask

  // Compare process: every cycle, both instances, away from the active edge.
  always @(negedge clk) begin
    if (!arst_l) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 1'b0;
        m_ptr[k]  = 1'b0;
      end
    end else begin
      model_cycle(0);
      model_cycle(1);
    end
    last_ack[0] = ack[0];
    last_ack[1] = ack[1];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      vld[k] = 2'b00; kl[k] = 2'b00; sg[k] = 2'b00; d0[k] = '0; d1[k] = '0;
    end
  endtask

  task automatic do_reset();
    arst_l = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d reset ack", k), ack[k], 64'h0);
      chk($sformatf("i%0d reset eql_in", k), ein[k], 64'h0);
      chk($sformatf("i%0d reset rsp", k), {rv[k], rid[k], rov[k], rsat[k]}, 64'h0);
    end
    cyc();
    arst_l = 1'b1;
  endtask

  // One isolated request with hand-computed latency and result.
  task automatic run_one(input int k, input bit r, input logic [63:0] d, input bit s,
                         input int xlat, input bit xov, input logic [31:0] xsat, input string nm);
    bit got;
    int lat;
    if (r) d1[k] = d; else d0[k] = d;
    sg[k][r]  = s;
    vld[k][r] = 1'b1;
    @(negedge clk);
    chk($sformatf("%s ack", nm), ack[k], r ? 2'b10 : 2'b01);
    cyc();
    vld[k][r] = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int t = 1; t <= 12 && !got; t++) begin
      @(negedge clk);
      if (rv[k]) begin
        got = 1'b1;
        lat = t;
      end else begin
        @(posedge clk);
      end
    end
    if (!got) begin
      chk($sformatf("%s timeout", nm), 64'd0, 64'd1);
    end else begin
      chk($sformatf("%s latency", nm), lat, xlat);
      chk($sformatf("%s id", nm), rid[k], r);
      chk($sformatf("%s ovfl", nm), rov[k], xov);
      chk($sformatf("%s sat", nm), rsat[k], xsat);
    end
    cyc();
  endtask

  function automatic logic [63:0] rand_data();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: v[63:32] = 32'h0;
      1: v[63:32] = 32'hFFFF_FFFF;
      2: v[63:31] = {32'h0, 1'b1};
      3: v[63:31] = {32'hFFFF_FFFF, 1'b0};
      4: v[63:32] = ($urandom_range(0, 1) == 1) ? 32'h1 : 32'hFFFF_FFFE;
      default: ;
    endcase
    return v;
  endfunction

  task automatic rand_drive(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      for (int r = 0; r < 2; r++) begin
        kl[k][r] = ($urandom_range(0, 24) == 0);
        if (vld[k][r] && !last_ack[k][r]) begin
          if ($urandom_range(0, 15) == 0) vld[k][r] = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          vld[k][r] = 1'b1;
          sg[k][r]  = $urandom_range(0, 1);
          if (r == 0) d0[k] = rand_data(); else d1[k] = rand_data();
        end else begin
          vld[k][r] = 1'b0;
        end
      end
      cyc();
    end
  endtask

  int ack_seq [$];
  int ack_cyc [$];

  initial begin
    arst_l = 1'b0;
    clear_inputs();
    do_reset();
    cyc();

    run_one(0, 1'b0, 64'h0000_0000_1234_5678, 1'b0, 2, 1'b0, 32'h0,         "u_small");
    run_one(0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1, 3, 1'b0, 32'h0,         "s_minint");
    run_one(0, 1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 1'b1, 3, 1'b1, 32'h8000_0000, "s_below");
    run_one(0, 1'b0, 64'h0000_0001_0000_0000, 1'b1, 2, 1'b1, 32'h7FFF_FFFF, "s_early");
    run_one(0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 2, 1'b1, 32'hFFFF_FFFF, "u_big");
    run_one(1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1, 5, 1'b0, 32'h0,         "lat1_s_minint");
    run_one(1, 1'b0, 64'h0000_0001_0000_0000, 1'b1, 3, 1'b1, 32'h7FFF_FFFF, "lat1_s_early");

    // Both requesters held: grants alternate starting from requester 0, every 3 cycles.
    do_reset();
    d0[0] = 64'h5; d1[0] = 64'h7; sg[0] = 2'b00; vld[0] = 2'b11;
    for (int c = 0; c < 40 && ack_seq.size() < 6; c++) begin
      @(negedge clk);
      if (ack[0] != 2'b00) begin
        ack_seq.push_back(ack[0] == 2'b10 ? 1 : 0);
        ack_cyc.push_back(c);
      end
      cyc();
    end
    vld[0] = 2'b00;
    chk("rr ack count", ack_seq.size(), 6);
    for (int i = 0; i < ack_seq.size(); i++) begin
      chk($sformatf("rr grant%0d", i), ack_seq[i], i % 2);
      if (i > 0) chk($sformatf("rr gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
    end
    repeat (4) cyc();

    // Owner killed in P2; pending requester 1 acked in the following IDLE cycle.
    do_reset();
    d0[0] = 64'hFFFF_FFFF_8000_0000; sg[0] = 2'b01; d1[0] = 64'h9; vld[0] = 2'b11;
    @(negedge clk);
    chk("kill c0 ack", ack[0], 2'b01);
    cyc();
    vld[0] = 2'b10;
    @(negedge clk);
    chk("kill c1 ack", ack[0], 2'b00);
    cyc();
    kl[0] = 2'b01;
    @(negedge clk);
    chk("kill c2 rsp_vld", rv[0], 1'b0);
    cyc();
    kl[0] = 2'b00;
    @(negedge clk);
    chk("kill c3 ack", ack[0], 2'b10);
    chk("kill c3 rsp_vld", rv[0], 1'b0);
    cyc();
    vld[0] = 2'b00;
    repeat (4) cyc();

    // Reset pulsed while instance 1 sits in P1W.
    d0[1] = 64'hFFFF_FFFF_8000_0000; sg[1] = 2'b01; vld[1] = 2'b01;
    @(negedge clk);
    chk("arst c0 ack", ack[1], 2'b01);
    cyc();
    vld[1] = 2'b00;
    cyc();
    chk("arst p1w eql_in", ein[1], 32'hFFFF_FFFF);
    arst_l = 1'b0;
    #1;
    chk("arst ack", ack[1], 64'h0);
    chk("arst eql_in", ein[1], 64'h0);
    chk("arst rsp", {rv[1], rid[1], rov[1], rsat[1]}, 64'h0);
    @(posedge clk);
    #2;
    arst_l = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("arst no rsp", rv[1], 1'b0);
    end
    cyc();

    fork
      rand_drive(0, 3000);
      rand_drive(1, 3000);
    join
    clear_inputs();
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
